fetch: RTL and testbench

Instruction-fetch stage of PIGRO, directly upstream of decode. Keeps the 5-bit program counter and drives a synchronous-read instruction memory. Delivers one `{instruction_out, pc_out}` pair per cycle to decode, and honours decode's `stall` and `jump_flag`/`jump_dest` feedback. A one-entry skid register means a stall never loses or re-fetches the word already in flight.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid.sv | 31 +++
 rtl/fetch.sv | 142 ++++++++++++++
 tb/tb_fetch.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the PIGRO fetch stage: FSM encoding and the
// instruction that is presented to decode while no real word is available.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_FILL,
    S_RUN,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register for fetch: parks the in-flight word and its pc
// while decode stalls, so the word is neither lost nor re-fetched.
module fetch_skid #(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            clear,
  input  logic [31:0]     cap_data,
  input  logic [PC_W-1:0] cap_pc,
  output logic            valid,
  output logic [31:0]     data,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= cap_data;
      pc    <= cap_pc;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch.sv
// PIGRO instruction fetch: owns the pc, drives a synchronous-read imem and
// hands {instruction, pc} to decode, honouring stall and jump feedback.
module fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W         = 5,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter bit              HALT_ON_WRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jump_flag,
  input  logic [PC_W-1:0] jump_dest,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instruction_out,
  output logic [PC_W-1:0] pc_out,
  output logic            halted
);

  localparam logic [PC_W-1:0] PC_MAX = '1;

  state_t          state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_nxt;
  logic            infl_valid, infl_valid_nxt;
  logic [PC_W-1:0] infl_pc, infl_pc_nxt;
  logic [31:0]     instr_nxt;
  logic [PC_W-1:0] pco_nxt;
  logic            halted_nxt;
  logic            skid_cap, skid_clr, skid_valid;
  logic [31:0]     skid_data;
  logic [PC_W-1:0] skid_pc;
  logic            wrap_stop;

  // imem sees the pc register directly; stall/jump only act on the next edge.
  assign imem_addr = fetch_pc;
  assign wrap_stop = HALT_ON_WRAP && (fetch_pc == PC_MAX);

  fetch_skid #(.PC_W(PC_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture  (skid_cap),
    .clear    (skid_clr),
    .cap_data (imem_data),
    .cap_pc   (infl_pc),
    .valid    (skid_valid),
    .data     (skid_data),
    .pc       (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_FILL;
      fetch_pc        <= RESET_PC;
      infl_valid      <= 1'b0;
      infl_pc         <= '0;
      instruction_out <= NOP;
      pc_out          <= '0;
      halted          <= 1'b0;
    end else begin
      state           <= state_nxt;
      fetch_pc        <= fetch_nxt;
      infl_valid      <= infl_valid_nxt;
      infl_pc         <= infl_pc_nxt;
      instruction_out <= instr_nxt;
      pc_out          <= pco_nxt;
      halted          <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_nxt      = fetch_pc;
    infl_valid_nxt = infl_valid;
    infl_pc_nxt    = infl_pc;
    instr_nxt      = instruction_out;
    pco_nxt        = pc_out;
    halted_nxt     = halted;
    skid_cap       = 1'b0;
    skid_clr       = 1'b0;
    case (state)
      S_FILL: begin
        infl_valid_nxt = 1'b1;
        infl_pc_nxt    = fetch_pc;
        if (wrap_stop) state_nxt = S_DRAIN;
        else begin
          fetch_nxt = fetch_pc + 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN, S_HOLD, S_DRAIN: begin
        if (stall) begin
          // Outputs and pc freeze; only the word already in flight is kept.
          if (infl_valid && !skid_valid) skid_cap = 1'b1;
          infl_valid_nxt = 1'b0;
          if (state == S_RUN) state_nxt = S_HOLD;
        end else if (jump_flag) begin
          fetch_nxt      = jump_dest;
          infl_valid_nxt = 1'b0;
          skid_clr       = 1'b1;
          instr_nxt      = NOP;
          pco_nxt        = '0;
          state_nxt      = S_RUN;
        end else begin
          if (skid_valid) begin
            instr_nxt = skid_data;
            pco_nxt   = skid_pc;
          end else if (infl_valid) begin
            instr_nxt = imem_data;
            pco_nxt   = infl_pc;
          end else begin
            instr_nxt = NOP;
            pco_nxt   = '0;
          end
          skid_clr = 1'b1;
          if (state == S_DRAIN) begin
            infl_valid_nxt = 1'b0;
            state_nxt      = S_HALT;
          end else begin
            infl_valid_nxt = 1'b1;
            infl_pc_nxt    = fetch_pc;
            // Last address: keep fetch_pc parked and let the final word drain.
            if (wrap_stop) state_nxt = S_DRAIN;
            else begin
              fetch_nxt = fetch_pc + 1'b1;
              state_nxt = S_RUN;
            end
          end
        end
      end
      S_HALT: begin
        instr_nxt      = NOP;
        pco_nxt        = '0;
        halted_nxt     = 1'b1;
        infl_valid_nxt = 1'b0;
      end
      default: state_nxt = S_FILL;
    endcase
  end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: two instances (halt-on-wrap and wrapping) share
// stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, jump_flag;
  logic [4:0]  jump_dest;
  logic [4:0]  addr_h, addr_w, pc_h, pc_w;
  logic [31:0] data_h, data_w, ins_h, ins_w;
  logic        halt_h, halt_w;
  logic [31:0] mem [32];

  typedef struct packed {
    logic [31:0] ins;
    logic [4:0]  pc;
    logic        halt;
  } exp_t;

  exp_t q_h[$];
  exp_t q_w[$];
  exp_t e_h, e_w;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch #(.PC_W(5), .RESET_PC(5'd0), .HALT_ON_WRAP(1'b1)) u_halt (
    .clk(clk), .rst(rst), .stall(stall), .jump_flag(jump_flag), .jump_dest(jump_dest),
    .imem_addr(addr_h), .imem_data(data_h), .instruction_out(ins_h), .pc_out(pc_h),
    .halted(halt_h)
  );

  fetch #(.PC_W(5), .RESET_PC(5'd0), .HALT_ON_WRAP(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .jump_flag(jump_flag), .jump_dest(jump_dest),
    .imem_addr(addr_w), .imem_data(data_w), .instruction_out(ins_w), .pc_out(pc_w),
    .halted(halt_w)
  );

  initial for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;

  always @(posedge clk) begin
    data_h <= mem[addr_h];
    data_w <= mem[addr_w];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_h.size() > 0) begin
        e_h = q_h.pop_front();
        chk("halt_dut.instr", ins_h, e_h.ins);
        chk("halt_dut.pc", {27'b0, pc_h}, {27'b0, e_h.pc});
        chk("halt_dut.halted", {31'b0, halt_h}, {31'b0, e_h.halt});
      end
      if (q_w.size() > 0) begin
        e_w = q_w.pop_front();
        chk("wrap_dut.instr", ins_w, e_w.ins);
        chk("wrap_dut.pc", {27'b0, pc_w}, {27'b0, e_w.pc});
        chk("wrap_dut.halted", {31'b0, halt_w}, {31'b0, e_w.halt});
      end
    end
  end

  // Drive one cycle of inputs and queue what each DUT must show after the edge.
  task automatic step(input logic r, input logic s, input logic j, input logic [4:0] d,
                      input logic [31:0] ih, input logic [4:0] ph, input logic hh,
                      input logic [31:0] iw, input logic [4:0] pw, input logic hw);
    @(negedge clk);
    rst       = r;
    stall     = s;
    jump_flag = j;
    jump_dest = d;
    q_h.push_back(exp_t'{ih, ph, hh});
    q_w.push_back(exp_t'{iw, pw, hw});
  endtask

  task automatic both(input logic r, input logic s, input logic j, input logic [4:0] d,
                      input logic [31:0] i, input logic [4:0] p);
    step(r, s, j, d, i, p, 1'b0, i, p, 1'b0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; jump_flag = 1'b0; jump_dest = 5'd0;
    // reset and fill
    both(0, 0, 0, 0, 32'h0, 0);
    both(0, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h100, 0);
    both(1, 0, 0, 0, 32'h101, 1);
    both(1, 0, 0, 0, 32'h102, 2);
    // 3-cycle stall with 0x103 in flight
    for (int k = 0; k < 3; k++) both(1, 1, 0, 0, 32'h102, 2);
    both(1, 0, 0, 0, 32'h103, 3);
    both(1, 0, 0, 0, 32'h104, 4);
    both(1, 0, 0, 0, 32'h105, 5);
    // jump to 20: two bubbles
    both(1, 0, 1, 20, 32'h0, 0);
    both(1, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h114, 20);
    both(1, 0, 0, 0, 32'h115, 21);
    // run to the top of the address space
    for (int p = 22; p < 32; p++) both(1, 0, 0, 0, 32'h100 + p, p[4:0]);
    // halt instance stops; wrapping instance continues from 0
    step(1, 0, 0, 0, 32'h0, 0, 1, 32'h100, 0, 0);
    step(1, 0, 0, 0, 32'h0, 0, 1, 32'h101, 1, 0);
    step(1, 1, 0, 0, 32'h0, 0, 1, 32'h101, 1, 0);
    step(1, 0, 0, 0, 32'h0, 0, 1, 32'h102, 2, 0);
    step(1, 0, 1, 7, 32'h0, 0, 1, 32'h0, 0, 0);
    step(1, 0, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
    // reset out of HALT, then jump taken while draining the last word
    both(0, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h100, 0);
    both(1, 0, 1, 29, 32'h0, 0);
    both(1, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h11D, 29);
    both(1, 0, 0, 0, 32'h11E, 30);
    both(1, 0, 1, 3, 32'h0, 0);
    both(1, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h103, 3);
    both(1, 0, 0, 0, 32'h104, 4);
    // reset while stalled with a full skid
    both(1, 1, 0, 0, 32'h104, 4);
    both(1, 1, 0, 0, 32'h104, 4);
    both(0, 1, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h0, 0);
    both(1, 0, 0, 0, 32'h100, 0);
    both(1, 0, 0, 0, 32'h101, 1);
    both(1, 0, 0, 0, 32'h102, 2);
    @(negedge clk);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q_h.size() != 0 || q_w.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left_h=%0d left_w=%0d want=0", q_h.size(), q_w.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
